// File: rtl/wb_pipe_reg.sv
// Write-back pipeline register: DEPTH-stage shift of write-back control and data
// with stall hold, flush squash and a saturating stall-cycle counter.
module wb_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RD_W  = 5,
    parameter int unsigned DEPTH = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            RegWrite_i,
    input  logic            MemToReg_i,
    input  logic [XLEN-1:0] ALUresult_i,
    input  logic [XLEN-1:0] Readdata_i,
    input  logic [RD_W-1:0] RdAddr_i,
    input  logic            MemStall_i,
    input  logic            Flush_i,
    output logic            valid_o,
    output logic            RegWrite_o,
    output logic            MemToReg_o,
    output logic [XLEN-1:0] ALUresult_o,
    output logic [XLEN-1:0] Readdata_o,
    output logic [RD_W-1:0] RdAddr_o,
    output logic [XLEN-1:0] WBdata_o,
    output logic [15:0]     stall_cnt_o
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memtoreg;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [RD_W-1:0] rd;
    } stage_t;

    stage_t [DEPTH-1:0] stage_q;
    stage_t [DEPTH-1:0] shift_c;
    stage_t             entry_c;
    logic [CNT_W-1:0]   stall_cnt_q;

    // Stage 0 capture; a write to register 0 or from an empty slot is dropped here.
    always_comb begin
        entry_c          = '0;
        entry_c.valid    = valid_i;
        entry_c.regwrite = RegWrite_i & valid_i & (RdAddr_i != '0);
        entry_c.memtoreg = MemToReg_i;
        entry_c.alu      = ALUresult_i;
        entry_c.rdata    = Readdata_i;
        entry_c.rd       = RdAddr_i;
    end

    assign shift_c[0] = entry_c;
    for (genvar k = 1; k < DEPTH; k++) begin : g_shift
        assign shift_c[k] = stage_q[k-1];
    end

    // Flush wins over stall; stall freezes every stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else if (Flush_i) begin
            stage_q <= '0;
        end else if (!MemStall_i) begin
            stage_q <= shift_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (MemStall_i && !Flush_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // regwrite is only ever set together with valid, so the stored bit already equals regwrite & valid.
    assign valid_o     = stage_q[DEPTH-1].valid;
    assign RegWrite_o  = stage_q[DEPTH-1].regwrite;
    assign MemToReg_o  = stage_q[DEPTH-1].memtoreg;
    assign ALUresult_o = stage_q[DEPTH-1].alu;
    assign Readdata_o  = stage_q[DEPTH-1].rdata;
    assign RdAddr_o    = stage_q[DEPTH-1].rd;
    assign stall_cnt_o = stall_cnt_q;
    assign WBdata_o    = stage_q[DEPTH-1].memtoreg ? stage_q[DEPTH-1].rdata : stage_q[DEPTH-1].alu;

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the data path width in bits.
REQ-002 The block SHALL take parameter RD_W, default 5, as the destination register index width.
REQ-003 The block SHALL take parameter DEPTH, default 1, legal range 1..4, as the number of register stages.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, named as follows: clk_i  input  1  rising-edge clock.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 valid_i  input  1  incoming slot holds a real instruction.
REQ-007 RegWrite_i  input  1  instruction writes the register file.
REQ-008 MemToReg_i  input  1  selects Readdata over ALUresult for write-back.
REQ-009 ALUresult_i  input  XLEN  ALU result.
REQ-010 Readdata_i  input  XLEN  data memory read data.
REQ-011 RdAddr_i  input  RD_W  destination register index.
REQ-012 MemStall_i  input  1  hold all stages.
REQ-013 Flush_i  input  1  squash all stages.
REQ-014 valid_o, RegWrite_o, MemToReg_o  output  1 each  last-stage fields.
REQ-015 ALUresult_o, Readdata_o  output  XLEN each  last-stage data.
REQ-016 RdAddr_o  output  RD_W  last-stage destination index.
REQ-017 WBdata_o  output  XLEN  write-back value of last stage.
REQ-018 stall_cnt_o  output  16  count of stalled cycles.

Function
REQ-019 The block SHALL implement a DEPTH-entry shift pipeline; each stage stores valid, RegWrite, MemToReg, ALUresult, Readdata, RdAddr.
REQ-020 With MemStall_i=0 and Flush_i=0, every rising edge SHALL load stage 0 from inputs and stage k from stage k-1; input-to-output latency SHALL be exactly DEPTH cycles.
REQ-021 Stage 0 capture SHALL store RegWrite as RegWrite_i & valid_i & (RdAddr_i != 0); writes to register 0 are squashed at entry.
REQ-022 With MemStall_i=1 and Flush_i=0, all stages SHALL hold their contents; inputs are not captured.
REQ-023 With Flush_i=1, every stage SHALL clear valid and RegWrite at the next edge; data, MemToReg and RdAddr fields SHALL be don't-care but SHALL be cleared to 0.
REQ-024 Flush_i SHALL take precedence over MemStall_i when both are 1.
REQ-025 RegWrite_o SHALL equal last-stage RegWrite AND last-stage valid.
REQ-026 WBdata_o SHALL be combinational: last-stage Readdata when MemToReg_o=1, else last-stage ALUresult.
REQ-027 stall_cnt_o SHALL increment by 1 on each edge with MemStall_i=1 and Flush_i=0, saturate at 16'hFFFF, and never wrap.
REQ-028 stall_cnt_o SHALL not change on flush cycles or non-stall cycles.
REQ-029 All outputs other than WBdata_o SHALL be driven directly from registers.

Reset
REQ-030 Asserting rst_i SHALL immediately, without a clock edge, clear every stage field and stall_cnt_o to 0.
REQ-031 During reset, valid_o, RegWrite_o, MemToReg_o, RdAddr_o, ALUresult_o, Readdata_o, WBdata_o and stall_cnt_o SHALL all read 0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion SHALL behave per REQ-020..REQ-024.

Verification
REQ-033 DEPTH=1: valid_i=1, RegWrite_i=1, MemToReg_i=0, ALUresult_i=32'h1234, RdAddr_i=5 -> after 1 edge RegWrite_o=1, RdAddr_o=5, WBdata_o=32'h1234.
REQ-034 DEPTH=3: inject three back-to-back instructions with Readdata_i=A,B,C, MemToReg_i=1 -> WBdata_o shows A,B,C on edges 3,4,5 in order.
REQ-035 DEPTH=2: hold MemStall_i=1 for 4 cycles mid-stream -> outputs frozen 4 cycles, no instruction lost or duplicated, stall_cnt_o=4.
REQ-036 MemStall_i=1 and Flush_i=1 in the same cycle -> next edge valid_o=0, RegWrite_o=0, stall_cnt_o unchanged.
REQ-037 valid_i=1, RegWrite_i=1, RdAddr_i=0 -> RegWrite_o=0 at output while valid_o=1; and valid_i=0, RegWrite_i=1 -> RegWrite_o=0.
REQ-038 Preload stall_cnt_o to 16'hFFFE by stalling, stall 3 more cycles -> stall_cnt_o=16'hFFFF; then assert rst_i asynchronously between edges -> all outputs 0 immediately.
